sd_blk_arbiter: RTL



---
 rtl/sd_blk_arbiter.sv | 89 ++++++++
 1 files changed

// File: rtl/sd_blk_arbiter.sv
// sd_blk_arbiter: round-robin sharing of one host block-I/O port among NUM SD front-ends.
// Define SD_ARB_TIMEOUT_EN to abandon requests the host never acks.
module sd_blk_arbiter #(
  parameter int NUM  = 4,
  parameter int WIDE = 0,
  parameter int TO_W = 20
) (
  input  logic                            clk_sys,
  input  logic                            reset,
  input  logic [NUM*32-1:0]               req_lba,
  input  logic [NUM-1:0]                  req_rd,
  input  logic [NUM-1:0]                  req_wr,
  output logic [NUM-1:0]                  req_ack,
  input  logic [NUM*(WIDE ? 16 : 8)-1:0]  req_buff_din,
  output logic [31:0]                     hps_lba,
  output logic                            hps_rd,
  output logic                            hps_wr,
  output logic [1:0]                      hps_dev,
  input  logic                            hps_ack,
  output logic [(WIDE ? 16 : 8)-1:0]      hps_buff_din,
  output logic                            busy,
  output logic                            timeout_err
);
  localparam int BW = WIDE ? 16 : 8;
  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;
  state_t state;
  logic [1:0] rr, g;
  logic hit, to_hit;
  logic [NUM-1:0] p;
  assign p = req_rd | req_wr;
  // Scan downward so the lowest offset from rr wins.
  always_comb begin
    g = '0;
    hit = 1'b0;
    for (int k = NUM - 1; k >= 0; k--)
      if (p[(int'(rr) + k) % NUM]) begin
        g = 2'((int'(rr) + k) % NUM);
        hit = 1'b1;
      end
  end
  always_comb begin
    req_ack = '0;
    for (int i = 0; i < NUM; i++)
      req_ack[i] = hps_ack && (state == REQ || state == XFER) && hps_dev == 2'(i);
  end
  assign hps_buff_din = req_buff_din[int'(hps_dev)*BW +: BW];
`ifdef SD_ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  assign to_hit = &to_cnt && !hps_ack;
  always_ff @(posedge clk_sys) begin
    to_cnt <= (!reset && state == REQ) ? to_cnt + 1'b1 : '0;
    timeout_err <= !reset && state == REQ && to_hit;
  end
`else
  assign to_hit = 1'b0;
  assign timeout_err = 1'b0 && TO_W > 0;
`endif
  always_ff @(posedge clk_sys)
    if (reset) begin
      state <= IDLE;
      rr <= '0;
      hps_lba <= '0;
      hps_dev <= '0;
      hps_rd <= 1'b0;
      hps_wr <= 1'b0;
      busy <= 1'b0;
    end else
      case (state)
        IDLE: if (hit) begin
          state <= REQ;
          busy <= 1'b1;
          hps_dev <= g;
          hps_lba <= req_lba[int'(g)*32 +: 32];
          hps_rd <= req_rd[g];
          hps_wr <= !req_rd[g];
        end
        REQ: if (hps_ack || to_hit) begin
          state <= hps_ack ? XFER : DONE;
          hps_rd <= 1'b0;
          hps_wr <= 1'b0;
        end
        XFER: if (!hps_ack) state <= DONE;
        default: begin
          state <= IDLE;
          busy <= 1'b0;
          rr <= 2'((int'(hps_dev) + 1) % NUM);
        end
      endcase
endmodule
